// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped GPIO peripheral with edge-triggered interrupts.
//
// Register map (word index = mem_addr[4:2]):
//   0 DATA_OUT (RW)  1 DIR (RW)  2 DATA_IN (RO)  3 SET (WO)  4 CLR (WO)
//   5 IRQ_EN (RW)    6 IRQ_PEND (W1C)            7 EDGE_SEL (RW, 1 = falling)
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   sel             - peripheral selected by the SoC address decode
//   mem_addr        - byte address, bits [1:0] ignored
//   mem_rstrb       - read request, data returned on mem_rdata one clock later
//   mem_wmask       - byte-lane write enables, nonzero means write
//   mem_wdata       - write data
//   mem_rdata       - registered read data, upper unused bits read 0
//   gpio_in         - asynchronous pin inputs
//   gpio_out        - DATA_OUT register
//   gpio_oe         - DIR register (1 = drive)
//   irq             - level interrupt, |(IRQ_PEND & IRQ_EN)
module gpio_mmio #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [4:0]       mem_addr,
    input  logic             mem_rstrb,
    input  logic [3:0]       mem_wmask,
    input  logic [31:0]      mem_wdata,
    output logic [31:0]      mem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] IDX_DATA_OUT = 3'd0;
    localparam logic [2:0] IDX_DIR      = 3'd1;
    localparam logic [2:0] IDX_DATA_IN  = 3'd2;
    localparam logic [2:0] IDX_SET      = 3'd3;
    localparam logic [2:0] IDX_CLR      = 3'd4;
    localparam logic [2:0] IDX_IRQ_EN   = 3'd5;
    localparam logic [2:0] IDX_IRQ_PEND = 3'd6;
    localparam logic [2:0] IDX_EDGE_SEL = 3'd7;

    logic [2:0]       reg_idx;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] wbits;

    logic [WIDTH-1:0] data_out, data_out_nxt;
    logic [WIDTH-1:0] dir, dir_nxt;
    logic [WIDTH-1:0] irq_en, irq_en_nxt;
    logic [WIDTH-1:0] irq_pend, irq_pend_nxt;
    logic [WIDTH-1:0] edge_sel, edge_sel_nxt;
    logic [WIDTH-1:0] pend_clr;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] s1, s2, s3;
    logic [31:0]      rd_val;
    logic             unused_bits;

    assign reg_idx = mem_addr[4:2];
    assign wr_en   = sel & (|mem_wmask);
    assign rd_en   = sel & mem_rstrb;

    // Byte address bits and write-data bits above WIDTH carry no meaning here.
    assign unused_bits = ^{mem_addr[1:0], mem_wdata};

    // Each pin bit belongs to the byte lane holding it; only bits in enabled
    // lanes may be touched by a write.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign lane_mask[i] = mem_wmask[i / 8];
    end

    assign wbits = mem_wdata[WIDTH-1:0] & lane_mask;

    // Edge detection compares the synchronised sample (s2) with its history
    // (s3), picking the polarity per pin. Because s3 follows s2, rewriting
    // EDGE_SEL alone never creates an event.
    assign edge_evt = (s2 & ~s3 & ~edge_sel) | (~s2 & s3 & edge_sel);

    assign gpio_out = data_out;
    assign gpio_oe  = dir;
    assign irq      = |(irq_pend & irq_en);

    // Next-state for the software-visible registers. Masked replace for the
    // plain RW registers, OR/AND-NOT for SET/CLR, and W1C for IRQ_PEND where
    // a fresh edge in the same cycle outranks the clear.
    always_comb begin
        data_out_nxt = data_out;
        dir_nxt      = dir;
        irq_en_nxt   = irq_en;
        edge_sel_nxt = edge_sel;
        pend_clr     = '0;
        if (wr_en) begin
            case (reg_idx)
                IDX_DATA_OUT: data_out_nxt = (data_out & ~lane_mask) | wbits;
                IDX_DIR:      dir_nxt      = (dir & ~lane_mask) | wbits;
                IDX_SET:      data_out_nxt = data_out | wbits;
                IDX_CLR:      data_out_nxt = data_out & ~wbits;
                IDX_IRQ_EN:   irq_en_nxt   = (irq_en & ~lane_mask) | wbits;
                IDX_IRQ_PEND: pend_clr     = wbits;
                IDX_EDGE_SEL: edge_sel_nxt = (edge_sel & ~lane_mask) | wbits;
                default:      data_out_nxt = data_out;
            endcase
        end
        irq_pend_nxt = (irq_pend & ~pend_clr) | edge_evt;
    end

    // Read mux built from pre-edge register values, so a same-cycle write is
    // not visible to the read. SET/CLR have no storage and read as zero.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            IDX_DATA_OUT: rd_val[WIDTH-1:0] = data_out;
            IDX_DIR:      rd_val[WIDTH-1:0] = dir;
            IDX_DATA_IN:  rd_val[WIDTH-1:0] = s2;
            IDX_IRQ_EN:   rd_val[WIDTH-1:0] = irq_en;
            IDX_IRQ_PEND: rd_val[WIDTH-1:0] = irq_pend;
            IDX_EDGE_SEL: rd_val[WIDTH-1:0] = edge_sel;
            default:      rd_val = '0;
        endcase
    end

    // All state, including the pin synchroniser chain, is cleared by reset so
    // that pins held low after reset cannot produce a spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= OUT_RESET;
            dir       <= '0;
            irq_en    <= '0;
            irq_pend  <= '0;
            edge_sel  <= '0;
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            mem_rdata <= '0;
        end else begin
            data_out <= data_out_nxt;
            dir      <= dir_nxt;
            irq_en   <= irq_en_nxt;
            irq_pend <= irq_pend_nxt;
            edge_sel <= edge_sel_nxt;
            s1       <= gpio_in;
            s2       <= s1;
            s3       <= s2;
            if (rd_en) begin
                mem_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_gpio_mmio.sv
// tb_gpio_mmio: self-checking bench for gpio_mmio (WIDTH=8, nonzero OUT_RESET).
// Directed scenarios for the documented use cases followed by a randomized
// phase, all checked against a behavioural model of the register map.
module tb_gpio_mmio;

    localparam int         W       = 8;
    localparam logic [7:0] OUT_RST = 8'h5A;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [4:0]  mem_addr;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Model state: register contents, last read data, and the pin values the
    // peripheral sampled on the last three clock edges (newest first).
    logic [7:0]  m_out, m_dir, m_en, m_pend, m_esel;
    logic [31:0] m_rdata;
    logic [7:0]  pin_hist [3];

    gpio_mmio #(
        .WIDTH     (W),
        .OUT_RESET (OUT_RST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] idx, input logic rd,
                                 input logic [3:0] wm, input logic [31:0] wd);
        sel       = s;
        mem_addr  = {idx, 2'($urandom_range(0, 3))};
        mem_rstrb = rd;
        mem_wmask = wm;
        mem_wdata = wd;
    endtask

    // Behavioural view of one clock edge: a write lands, a read returns the
    // old value, and a pin edge is seen once the pin has been sampled twice.
    task automatic modelEdge();
        logic [7:0] wv, ev, rise, fall, rd_reg;
        if (reset) begin
            m_out = OUT_RST; m_dir = 0; m_en = 0; m_pend = 0; m_esel = 0;
            m_rdata = 0;
            pin_hist[0] = 0; pin_hist[1] = 0; pin_hist[2] = 0;
            return;
        end
        // With 8 pins only byte lane 0 matters.
        wv   = mem_wmask[0] ? mem_wdata[7:0] : 8'h00;
        rise = pin_hist[1] & ~pin_hist[2];
        fall = ~pin_hist[1] & pin_hist[2];
        ev   = (rise & ~m_esel) | (fall & m_esel);
        if (sel && mem_rstrb) begin
            case (mem_addr[4:2])
                3'd0:    rd_reg = m_out;
                3'd1:    rd_reg = m_dir;
                3'd2:    rd_reg = pin_hist[1];
                3'd5:    rd_reg = m_en;
                3'd6:    rd_reg = m_pend;
                3'd7:    rd_reg = m_esel;
                default: rd_reg = 0;
            endcase
            m_rdata = {24'h0, rd_reg};
        end
        if (sel && mem_wmask != 0 && mem_wmask[0]) begin
            case (mem_addr[4:2])
                3'd0:    m_out  = wv;
                3'd1:    m_dir  = wv;
                3'd3:    m_out  = m_out | wv;
                3'd4:    m_out  = m_out & ~wv;
                3'd5:    m_en   = wv;
                3'd6:    m_pend = m_pend & ~wv;
                3'd7:    m_esel = wv;
                default: ;
            endcase
        end
        m_pend = m_pend | ev;
        pin_hist[2] = pin_hist[1];
        pin_hist[1] = pin_hist[0];
        pin_hist[0] = gpio_in;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("gpio_out", {24'h0, gpio_out}, {24'h0, m_out});
        checkOutput("gpio_oe", {24'h0, gpio_oe}, {24'h0, m_dir});
        checkOutput("irq", {31'h0, irq}, {31'h0, |(m_pend & m_en)});
        checkOutput("rdata", mem_rdata, m_rdata);
    endtask

    task automatic doWrite(input logic [2:0] idx, input logic [3:0] wm, input logic [31:0] wd);
        applyStimulus(1'b1, idx, 1'b0, wm, wd);
        tick();
    endtask

    task automatic doRead(input logic [2:0] idx);
        applyStimulus(1'b1, idx, 1'b1, 4'h0, $urandom);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 3'd0, 1'b0, 4'h0, 32'h0);
            tick();
        end
    endtask

    initial begin
        reset   = 1'b1;
        gpio_in = 8'h00;
        applyStimulus(1'b0, 3'd0, 1'b0, 4'h0, 32'h0);
        tick();
        tick();
        checkOutput("reset_out", {24'h0, gpio_out}, {24'h0, OUT_RST});
        checkOutput("reset_oe", {24'h0, gpio_oe}, 32'h0);
        checkOutput("reset_rdata", mem_rdata, 32'h0);
        reset = 1'b0;
        idle(3);

        // Masked writes, SET and CLR on DATA_OUT.
        doWrite(3'd0, 4'b0001, 32'h0000_00A5);
        checkOutput("wr_a5", {24'h0, gpio_out}, 32'hA5);
        doWrite(3'd3, 4'b0001, 32'h0000_000A);
        checkOutput("set_0a", {24'h0, gpio_out}, 32'hAF);
        doWrite(3'd4, 4'b0001, 32'h0000_0081);
        checkOutput("clr_81", {24'h0, gpio_out}, 32'h2E);
        doRead(3'd0);
        checkOutput("rd_2e", mem_rdata, 32'h2E);

        // Byte-lane masking and upper read bits.
        doWrite(3'd0, 4'b0001, 32'hFFFF_FFFF);
        checkOutput("wr_ff", {24'h0, gpio_out}, 32'hFF);
        doRead(3'd0);
        checkOutput("rd_ff", mem_rdata, 32'h0000_00FF);
        doWrite(3'd0, 4'b0010, 32'h0000_0000);
        checkOutput("lane1_nochg", {24'h0, gpio_out}, 32'hFF);
        doRead(3'd3);
        checkOutput("rd_set_zero", mem_rdata, 32'h0);

        // Rising edge on pin 3 with its interrupt enabled, then W1C.
        doWrite(3'd5, 4'b0001, 32'h08);
        gpio_in = 8'h08;
        idle(2);
        doRead(3'd2);
        checkOutput("datain_b3", mem_rdata, 32'h08);
        checkOutput("irq_b3", {31'h0, irq}, 32'h1);
        doWrite(3'd6, 4'b0001, 32'h08);
        checkOutput("irq_w1c", {31'h0, irq}, 32'h0);

        // Falling-edge select on pin 0.
        doWrite(3'd7, 4'b0001, 32'h01);
        gpio_in = 8'h09;
        idle(4);
        doRead(3'd6);
        checkOutput("fall_sel_rise", mem_rdata, 32'h00);
        gpio_in = 8'h08;
        idle(4);
        doRead(3'd6);
        checkOutput("fall_sel_fall", mem_rdata, 32'h01);

        // Edge and W1C on pin 5 in the same cycle: the set wins.
        doWrite(3'd6, 4'b0001, 32'hFF);
        gpio_in = 8'h28;
        idle(2);
        doWrite(3'd6, 4'b0001, 32'h20);
        doRead(3'd6);
        checkOutput("set_wins", mem_rdata, 32'h20);

        // Reset in the middle of activity.
        doWrite(3'd0, 4'b0001, 32'h3C);
        doWrite(3'd1, 4'b0001, 32'hFF);
        doWrite(3'd6, 4'b0001, 32'hFF);
        doWrite(3'd5, 4'b0001, 32'h01);
        gpio_in = 8'h29;
        idle(4);
        gpio_in = 8'h28;
        idle(4);
        doRead(3'd6);
        checkOutput("pend_01", mem_rdata, 32'h01);
        checkOutput("irq_pre_rst", {31'h0, irq}, 32'h1);
        reset = 1'b1;
        applyStimulus(1'b1, 3'd0, 1'b1, 4'b0001, 32'hFF);
        tick();
        checkOutput("rst_out", {24'h0, gpio_out}, {24'h0, OUT_RST});
        checkOutput("rst_oe", {24'h0, gpio_oe}, 32'h0);
        checkOutput("rst_irq", {31'h0, irq}, 32'h0);
        checkOutput("rst_rdata", mem_rdata, 32'h0);
        reset = 1'b0;

        // Randomized traffic on the bus and the pins.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] wm;
            case ($urandom_range(0, 3))
                0:       wm = 4'b0000;
                1:       wm = 4'b0001;
                2:       wm = 4'($urandom);
                default: wm = 4'b0010;
            endcase
            applyStimulus(1'($urandom), 3'($urandom), 1'($urandom), wm, $urandom);
            if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
